// File: rtl/fb_pkg.sv
// Shared types and defaults for the framebuffer RAM with clear engine.
package fb_pkg;

   localparam int FB_DEPTH      = 800;
   localparam int FB_DATA_WIDTH = 6;
   localparam int FB_ADDR_WIDTH = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } clr_state_e;

   // Address of the final word the clear engine writes.
   function automatic int clr_last_addr(input int depth);
      return depth - 1;
   endfunction

endpackage

// File: rtl/fb_clear_seq.sv
// Sequential clear engine: walks every word once, one per cycle, writing a
// latched fill value. Optionally arms an all-ones clear out of reset.
module fb_clear_seq
   import fb_pkg::*;
#(
   parameter int DEPTH        = FB_DEPTH,
   parameter int DATA_WIDTH   = FB_DATA_WIDTH,
   parameter int ADDR_WIDTH   = FB_ADDR_WIDTH,
   parameter int CLR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr_start,
   input  logic [DATA_WIDTH-1:0] clr_value,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr,
   output logic [DATA_WIDTH-1:0] clr_data,
   output logic                  clr_busy,
   output logic                  clr_done,
   output logic                  seq_idle
);

   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(clr_last_addr(DEPTH));

   clr_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] val_q, val_d;
   // Pending auto-clear: held through reset, consumed on the first idle cycle.
   logic                  pend_q, pend_d;

   // Next-state, counter and strobe generation.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      val_d    = val_q;
      pend_d   = pend_q;
      clr_we   = 1'b0;
      clr_busy = 1'b0;
      clr_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pend_q) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
               val_d   = '1;
               pend_d  = 1'b0;
            end else if (clr_start) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
               val_d   = clr_value;
            end
         end
         ST_CLEAR: begin
            clr_we   = 1'b1;
            clr_busy = 1'b1;
            // Counter parks on the last address; it never wraps.
            if (cnt_q == LAST) state_d = ST_DONE;
            else               cnt_d   = cnt_q + ADDR_WIDTH'(1);
         end
         ST_DONE: begin
            clr_done = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign clr_addr = cnt_q;
   assign clr_data = val_q;
   assign seq_idle = (state_q == ST_IDLE);

   // State register; reset abandons any clear in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         val_q   <= '0;
         pend_q  <= (CLR_ON_RESET != 0);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         val_q   <= val_d;
         pend_q  <= pend_d;
      end
   end

endmodule

// File: rtl/fb_ram_clr.sv
// Simple-dual-port framebuffer RAM with built-in clear engine.
// Write port is shared between user writes and the clear engine; the clear
// engine owns it while a clear runs. Read port has one cycle of latency.
// Build option FB_WR_FWD_EN: same-cycle write data is forwarded to a read of
// the same address; without it reads return old data and the array maps to
// a plain block RAM.
module fb_ram_clr
   import fb_pkg::*;
#(
   parameter int DEPTH        = FB_DEPTH,
   parameter int DATA_WIDTH   = FB_DATA_WIDTH,
   parameter int ADDR_WIDTH   = FB_ADDR_WIDTH,
   parameter int CLR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  clr_start,
   input  logic [DATA_WIDTH-1:0] clr_value,
   output logic                  clr_busy,
   output logic                  clr_done,
   output logic                  wr_drop
);

   localparam int                  AW1     = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = AW1'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic [DATA_WIDTH-1:0] clr_data;
   logic                  seq_idle;

   logic                  user_ok;
   logic                  we_m;
   logic [ADDR_WIDTH-1:0] waddr_m;
   logic [DATA_WIDTH-1:0] wdata_m;

   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  wr_drop_q, wr_drop_d;

   fb_clear_seq #(
      .DEPTH        (DEPTH),
      .DATA_WIDTH   (DATA_WIDTH),
      .ADDR_WIDTH   (ADDR_WIDTH),
      .CLR_ON_RESET (CLR_ON_RESET)
   ) u_seq (
      .clk       (clk),
      .reset     (reset),
      .clr_start (clr_start),
      .clr_value (clr_value),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr),
      .clr_data  (clr_data),
      .clr_busy  (clr_busy),
      .clr_done  (clr_done),
      .seq_idle  (seq_idle)
   );

   // User writes land only when the engine is idle and the address exists.
   assign user_ok = wr_en & seq_idle & ({1'b0, wr_addr} < DEPTH_W);

   // Write-port mux: clear engine has priority (the two never overlap anyway).
   always_comb begin
      we_m    = 1'b0;
      waddr_m = wr_addr;
      wdata_m = wr_data;
      if (clr_we) begin
         we_m    = 1'b1;
         waddr_m = clr_addr;
         wdata_m = clr_data;
      end else if (user_ok) begin
         we_m = 1'b1;
      end
   end

   // RAM array; never reset.
   always_ff @(posedge clk) begin
      if (we_m) mem[waddr_m] <= wdata_m;
   end

   // Read data / valid / drop next-state.
   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_en;
      wr_drop_d  = wr_en & ~user_ok;
      if (rd_en) begin
         if ({1'b0, rd_addr} < DEPTH_W) rd_data_d = mem[rd_addr];
         else                           rd_data_d = '0;
`ifdef FB_WR_FWD_EN
         if (we_m && (waddr_m == rd_addr)) rd_data_d = wdata_m;
`endif
      end
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         wr_drop_q  <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         wr_drop_q  <= wr_drop_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign wr_drop  = wr_drop_q;

endmodule
